// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int          MDU_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Remainder stays below the divisor, so a set top bit of the difference means a borrow.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional MDU_FAST_MULT_EN: single-cycle combinational MULT/MULTU; divides stay iterative.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MDU_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERS);

    mdu_state_t         r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_rem, r_q, r_dvs, r_a_raw;
    logic               r_sa, r_sb, r_div0, r_is_div;

    logic               w_signed, w_is_div, w_sa, w_sb;
    logic               w_launch, w_last, w_fast;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_launch = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CW'(ITERS - 1));

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    // Sign-extending both operands makes one 2W-bit multiplier serve signed and unsigned.
    assign w_fast      = w_launch && !w_is_div;
    assign w_fast_prod = {{WIDTH{w_sa}}, a} * {{WIDTH{w_sb}}, b};
`else
    assign w_fast = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start && !w_fast) w_state_nxt = w_is_div ? DIV : MUL;
            MUL, DIV: if (w_last) w_state_nxt = FIX;
            FIX:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == FIX) || w_fast;
            r_cnt   <= (r_state == MUL || r_state == DIV) ? r_cnt + 1'b1 : '0;
            if (r_state == FIX) begin
                {r_hi, r_lo} <= w_result;
            end else if (r_state == IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
`ifdef MDU_FAST_MULT_EN
                if (w_fast) {r_hi, r_lo} <= w_fast_prod;
`endif
            end
        end
    end

    // Shift-add multiply shares the rem/q pair with the divider: rem is the high half.
    assign w_mul_sum = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_dvs : '0)};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_div_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_q      <= mag(a, w_sa);
            r_dvs    <= mag(b, w_sb);
            r_rem    <= '0;
            r_a_raw  <= a;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_div0   <= (b == '0);
            r_is_div <= w_is_div;
        end else if (r_state == MUL) begin
            {r_rem, r_q} <= {w_mul_sum, r_q[WIDTH-1:1]};
        end else if (r_state == DIV) begin
            r_rem <= w_div_rem;
            r_q   <= {r_q[WIDTH-2:0], w_qbit};
        end
    end

    // Remainder follows the dividend's sign; divide-by-zero returns the raw dividend in HI.
    always_comb begin
        w_result = {r_rem, r_q};
        if (r_is_div) begin
            if (r_div0) w_result = {r_a_raw, DIV0_QUOT};
            else        w_result = {mag(r_rem, r_sa), mag(r_q, r_sa ^ r_sb)};
        end else if (r_sa ^ r_sb) begin
            w_result = -{r_rem, r_q};
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_hilo;
    import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] exp_hilo = '0;

    mdu_hilo dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // HI/LO as plain 64-bit arithmetic; SV / and % truncate toward zero like the ISA.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] q, r;
        case (o)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return 64'(ux * uy);
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = (o == OP_DIV) ? 64'(sx / sy) : 64'(ux / uy);
                r = (o == OP_DIV) ? 64'(sx % sy) : 64'(ux % uy);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, input bit disturb, input bit we_start);
        int lat = -1;
        int nbusy = 0;
        int exp_lat;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        hi_we = we_start; lo_we = we_start; wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom;
        exp_hilo = model(o, x, y);
        exp_lat = (FAST && (o == OP_MULT || o == OP_MULTU)) ? 0 : 33;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
            if (disturb && i == 5) begin
                start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_AAAA;
            end else if (disturb && i == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
        chk({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hilo[63:32]});
        chk({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_hilo[31:0]});
        @(posedge clk); #1;
        chk({tag, "_done_once"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int ndone;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg",  1'b0, 1'b0);
        run_op(OP_MULT,  32'd6,         32'd7,         "mult_6x7",  1'b0, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minsq", 1'b0, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7",  1'b0, 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,         "divu_100",  1'b0, 1'b0);
        run_op(OP_DIVU,  32'd5,         32'd0,         "divu_zero", 1'b0, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         "div_zero",  1'b0, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_wrap",  1'b0, 1'b0);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_posneg", 1'b0, 1'b0);
        run_op(OP_DIVU,  32'd1000,      32'd3,         "busy_ignore", 1'b1, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFF0, 32'd3,         "we_with_start", 1'b0, 1'b1);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_hi", {32'b0, hi}, 64'h1234);
        chk("mthi_lo", {32'b0, lo}, {32'b0, exp_hilo[31:0]});
        chk("mthi_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h0000_5678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo_lo", {32'b0, lo}, 64'h5678);
        chk("mtlo_hi", {32'b0, hi}, 64'h1234);
        chk("mtlo_done", {63'b0, done}, 64'd0);

        for (int k = 0; k < 16; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op(ro, ra, rb, $sformatf("rand%0d", k), 1'b0, 1'b0);
        end

        @(negedge clk);
        op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort_quiet", 64'(ndone), 64'd0);
        chk("abort_hi_kept", {32'b0, hi}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file.
- Operands are the two register-file read ports (rs value, rt value).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results stay in HI/LO and are read back by MFHI/MFLO.
- busy is the stall request to the decode/hazard logic.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, 32, shift-add / restoring-divide iterations (equals WIDTH)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  launch operation in op; sampled only while busy=0
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (register-file read data 1)
b  in  WIDTH  rt operand (register-file read data 2)
hi_we  in  1  MTHI: write wdata to HI
lo_we  in  1  MTLO: write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data (rs value)
busy  out  1  operation in flight; decode must stall MDU/MFHI/MFLO instructions
done  out  1  one-cycle pulse: HI/LO updated on previous edge
hi  out  WIDTH  HI register (registered)
lo  out  WIDTH  LO register (registered)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0. Reset aborts any in-flight operation; no partial result is written.
- State machine:
  - IDLE: start=1 at edge N latches op, |a| and |b| (magnitudes for signed ops; raw values for unsigned ops), and the sign bits. Moves to MUL or DIV with counter=0. busy=1 from the cycle after edge N.
  - MUL: shift-add, one bit per edge. After ITERS edges (N+1..N+32) moves to FIX.
  - DIV: restoring, one quotient bit per edge, same count. Moves to FIX.
  - FIX (edge N+33): applies signs and writes {HI,LO}. Returns to IDLE.
- Timing after FIX: done=1 and busy=0 in cycle N+33..N+34. Total latency is 33 edges from the start edge to the result edge.
- Sign rules:
  - MULT: 64-bit product negated when sa^sb.
  - DIV: quotient negated when sa^sb; remainder negated when sa. The remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU, b=0): LO=32'hFFFF_FFFF, HI=a (unmodified dividend). Latency is unchanged.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (wrap, no trap).
- start while busy=1: ignored; the in-flight operation is unaffected.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we while busy=0: the write takes effect at that edge.
- start with hi_we or lo_we at the same IDLE edge: the write is applied, and the operation result later overwrites both HI and LO.
- done is never asserted for MTHI/MTLO.
- Operands a/b are sampled only at the start edge; later changes are don't-care.

Optional Feature:
- Macro MDU_FAST_MULT_EN.
- Defined: MULT/MULTU compute the full 64-bit product combinationally. The result is written to HI/LO at the start edge N itself, done=1 in the following cycle, and busy stays 0. DIV/DIVU are unchanged (33 edges).
- Undefined: all four ops use the iterative path described above.

Decomposition:
- Package mdu_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (IDLE, MUL, DIV, FIX), MDU_ITERS=32, DIV0_QUOT=32'hFFFF_FFFF.
- One sub-module, mdu_div_step: combinational restoring-divide step. It shifts the remainder in by one dividend bit, trial-subtracts the divisor, and returns the new remainder and quotient bit. It is instantiated once inside mdu_hilo.

Test Plan:
- MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001; busy high 33 cycles; done pulses exactly once, at cycle 33.
- MULT a=0xFFFF_FFFD (-3) b=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB (-21).
- DIV a=-7 b=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=5 b=0 -> LO=0xFFFF_FFFF, HI=5. DIV a=0x8000_0000 b=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- While busy, pulse start (op=MULTU) and hi_we (wdata=0xAAAA) -> both ignored; original result unchanged. Then rst at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
- MTHI wdata=0x1234 in IDLE -> hi=0x1234 after the edge, done stays 0. With MDU_FAST_MULT_EN, MULT 6*7 -> LO=42, HI=0 after the start edge; busy never 1; done=1 for one cycle.
